// File: rtl/rom_arb_pkg.sv
// Shared constants for the instruction-ROM port arbiter: owner encoding
// for the read-response state machine and the debug burst counter width.
package rom_arb_pkg;

  localparam int unsigned BURST_W = 4;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_CORE = 2'd1;
  localparam logic [1:0] OWNER_DBG  = 2'd2;

endpackage : rom_arb_pkg

// File: rtl/rom_port_arb_if.sv
// Bundle of the fetch, debug and ROM-side signals around the ROM port
// arbiter. The slave modport is the arbiter's view; master is the
// surrounding requesters plus the ROM.
interface rom_port_arb_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();

  // fetch requester
  logic          core_req;
  logic [AW-1:0] core_addr;
  logic          core_gnt;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;

  // debug requester
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;

  // ROM port
  logic          rom_wen;
  logic [AW-1:0] rom_w_addr;
  logic [DW-1:0] rom_w_data;
  logic          rom_ren;
  logic [AW-1:0] rom_r_addr;
  logic [DW-1:0] rom_r_data;

  modport slave (
    input  core_req, core_addr,
    output core_gnt, core_rvalid, core_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output rom_wen, rom_w_addr, rom_w_data, rom_ren, rom_r_addr,
    input  rom_r_data
  );

  modport master (
    output core_req, core_addr,
    input  core_gnt, core_rvalid, core_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  rom_wen, rom_w_addr, rom_w_data, rom_ren, rom_r_addr,
    output rom_r_data
  );

endinterface : rom_port_arb_if

// File: rtl/rom_port_arb.sv
// Single instruction-ROM port arbiter between core fetch and JTAG debug.
// Debug wins by default; a burst counter hands the port to a pending fetch
// after DBG_BURST_MAX consecutive debug grants. halt_i blocks fetch fully.
// Read data returns one cycle after the grant, steered by the owner register.
// Optional build macro ROM_ARB_PERF_EN adds conflict/stall counters.
module rom_port_arb
  import rom_arb_pkg::*;
#(
  parameter int unsigned AW            = 32,
  parameter int unsigned DW            = 32,
  parameter int unsigned DBG_BURST_MAX = 4
`ifdef ROM_ARB_PERF_EN
  , parameter int unsigned CNT_W       = 16
`endif
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                halt_i,
  rom_port_arb_if.slave       bus
`ifdef ROM_ARB_PERF_EN
  , output logic [CNT_W-1:0]  perf_conflict_cnt
`endif
);

  localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(DBG_BURST_MAX);

  logic               fetch_ok;
  logic               core_gnt_c;
  logic               dbg_gnt_c;
  logic [BURST_W-1:0] burst_q;
  logic [BURST_W-1:0] burst_d;
  logic [1:0]         owner_q;
  logic [1:0]         owner_d;
  logic               rom_wen_c;
  logic               rom_ren_c;
  logic [AW-1:0]      r_addr_c;
  logic [AW-1:0]      w_addr_c;
  logic [DW-1:0]      w_data_c;
  logic               core_rvalid;
  logic               dbg_rvalid;

  // Grant decision: debug first unless it has used up its burst allowance
  always_comb begin
    fetch_ok   = bus.core_req & ~halt_i;
    dbg_gnt_c  = bus.dbg_req & (~fetch_ok | (burst_q < BURST_LIM));
    core_gnt_c = fetch_ok & ~dbg_gnt_c;
  end

  // ROM drive for the granted requester; idle port drives zeros
  always_comb begin
    rom_wen_c = 1'b0;
    rom_ren_c = 1'b0;
    r_addr_c  = '0;
    w_addr_c  = '0;
    w_data_c  = '0;
    if (core_gnt_c) begin
      rom_ren_c = 1'b1;
      r_addr_c  = bus.core_addr;
    end else if (dbg_gnt_c) begin
      if (bus.dbg_we) begin
        rom_wen_c = 1'b1;
        w_addr_c  = bus.dbg_addr;
        w_data_c  = bus.dbg_wdata;
      end else begin
        rom_ren_c = 1'b1;
        r_addr_c  = bus.dbg_addr;
      end
    end
  end

  // Next owner and burst count; burst only advances while fetch is waiting
  always_comb begin
    owner_d = OWNER_NONE;
    burst_d = '0;
    if (core_gnt_c) begin
      owner_d = OWNER_CORE;
    end else if (dbg_gnt_c && !bus.dbg_we) begin
      owner_d = OWNER_DBG;
    end
    if (dbg_gnt_c && fetch_ok) begin
      burst_d = (burst_q < BURST_LIM) ? burst_q + BURST_W'(1) : burst_q;
    end
  end

  // Owner and burst state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner_q <= OWNER_NONE;
      burst_q <= '0;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
    end
  end

  assign core_rvalid = (owner_q == OWNER_CORE);
  assign dbg_rvalid  = (owner_q == OWNER_DBG);

  assign bus.core_gnt    = core_gnt_c;
  assign bus.dbg_gnt     = dbg_gnt_c;
  assign bus.rom_wen     = rom_wen_c;
  assign bus.rom_ren     = rom_ren_c;
  assign bus.rom_r_addr  = r_addr_c;
  assign bus.rom_w_addr  = w_addr_c;
  assign bus.rom_w_data  = w_data_c;
  assign bus.core_rvalid = core_rvalid;
  assign bus.dbg_rvalid  = dbg_rvalid;
  assign bus.core_rdata  = core_rvalid ? bus.rom_r_data : '0;
  assign bus.dbg_rdata   = dbg_rvalid  ? bus.rom_r_data : '0;

`ifdef ROM_ARB_PERF_EN
  logic             conflict;
  logic             stall;
  logic [CNT_W-1:0] conflict_q;
  logic [CNT_W-1:0] stall_cnt_q;

  assign conflict = fetch_ok & bus.dbg_req;
  assign stall    = fetch_ok & ~core_gnt_c;

  // Saturating conflict and fetch-stall counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      conflict_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (conflict && (conflict_q != '1)) begin
        conflict_q <= conflict_q + CNT_W'(1);
      end
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign perf_conflict_cnt = conflict_q;
`endif

endmodule : rom_port_arb
